// File: rtl/minesweeper_pkg.sv
// Shared minesweeper definitions.
//  - field_t   : board cell byte layout (MSB first)
//  - MAX_SIZE  : physical board dimension; address = {row[3:0], col[3:0]}
//  - nb_ofs_t / NB_OFS : neighbour offsets (dr, dc) in sweep order k=0..7
//  - state_t   : indicator-calc sweep FSM states
//  - make_adr  : (row, col) -> board memory address
package minesweeper_pkg;

  localparam int MAX_SIZE = 16;

  typedef struct packed {
    logic       mine;
    logic       flag;
    logic       defused;
    logic [3:0] mine_ind;
    logic       rsvd;
  } field_t;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } nb_ofs_t;

  // Row-major sweep of the 3x3 ring, centre excluded.
  localparam nb_ofs_t NB_OFS [8] = '{
    '{2'sb11, 2'sb11}, '{2'sb11, 2'sb00}, '{2'sb11, 2'sb01},
    '{2'sb00, 2'sb11},                    '{2'sb00, 2'sb01},
    '{2'sb01, 2'sb11}, '{2'sb01, 2'sb00}, '{2'sb01, 2'sb01}
  };

  typedef enum logic [3:0] {
    S_IDLE, S_SELF_RD, S_SELF_WT, S_NB_EVAL, S_NB_WT,
    S_WR, S_WR_WT, S_ADV, S_DONE
  } state_t;

  function automatic logic [7:0] make_adr(input logic [3:0] row, input logic [3:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Minimal Wishbone bundle between the indicator-calc master and board memory.
//  master: drives CYC_O, STB_O, WE_O, ADR_O[7:0], DAT_O[7:0]; receives DAT_I[7:0], ACK_I
//  slave : the mirror image
interface wishbone_if;
  logic       CYC_O;
  logic       STB_O;
  logic       WE_O;
  logic [7:0] ADR_O;
  logic [7:0] DAT_O;
  logic [7:0] DAT_I;
  logic       ACK_I;

  modport master (output CYC_O, STB_O, WE_O, ADR_O, DAT_O, input DAT_I, ACK_I);
  modport slave  (input CYC_O, STB_O, WE_O, ADR_O, DAT_O, output DAT_I, ACK_I);
endinterface

// File: rtl/nb_addr_gen.sv
// Combinational neighbour address generator.
//  row, col  : centre cell
//  k         : neighbour index 0..7 (order from NB_OFS)
//  size      : active board dimension, 1..MAX_SIZE
//  in_bounds : neighbour lies inside the active size x size area
//  adr       : neighbour address (only meaningful when in_bounds)
module nb_addr_gen
  import minesweeper_pkg::*;
(
  input  logic [3:0] row,
  input  logic [3:0] col,
  input  logic [2:0] k,
  input  logic [4:0] size,
  output logic       in_bounds,
  output logic [7:0] adr
);
  nb_ofs_t           ofs;
  logic signed [5:0] nr;
  logic signed [5:0] nc;
  logic signed [5:0] lim;

  // 6-bit signed arithmetic so -1 and 16 are both representable.
  always_comb begin
    ofs       = NB_OFS[k];
    lim       = $signed({1'b0, size});
    nr        = $signed({2'b00, row}) + $signed({{4{ofs.dr[1]}}, ofs.dr});
    nc        = $signed({2'b00, col}) + $signed({{4{ofs.dc[1]}}, ofs.dc});
    in_bounds = !nr[5] && !nc[5] && (nr < lim) && (nc < lim);
    adr       = make_adr(nr[3:0], nc[3:0]);
  end

endmodule

// File: rtl/board_indicator_calc.sv
// Board indicator calculator: Wishbone writing master that sweeps the active
// board and writes each cell's neighbour-mine count into its mine_ind field.
//  clk, rst   : clock, synchronous active-high reset
//  start      : one-cycle pulse, accepted only in IDLE
//  board_size : active rows/cols, latched at start (0 -> 1, >MAX_SIZE -> MAX_SIZE)
//  busy       : high from the cycle after an accepted start through the done cycle
//  done       : one-cycle pulse at end of sweep (normal or aborted)
//  err        : valid with done; 1 = aborted on ACK timeout, held until next start
//  wb         : Wishbone master port to board memory
module board_indicator_calc
  import minesweeper_pkg::*;
#(
  parameter int MAX_SIZE    = minesweeper_pkg::MAX_SIZE,
  parameter int ACK_TIMEOUT = 15
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] board_size,
  output logic       busy,
  output logic       done,
  output logic       err,
  wishbone_if.master wb
);
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [3:0]        row_q, row_d;
  logic [3:0]        col_q, col_d;
  logic [2:0]        k_q, k_d;
  logic [3:0]        cnt_q, cnt_d;
  field_t            self_q, self_d;
  logic [4:0]        size_q, size_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;

  logic [4:0]        size_in;
  logic [4:0]        last;
  logic              nb_in;
  logic [7:0]        nb_adr;
  logic              is_wt;
  logic              timeout;
  logic              stb, we;
  logic [7:0]        adr, dat;
  field_t            wr_fld;

  nb_addr_gen u_nb (
    .row       (row_q),
    .col       (col_q),
    .k         (k_q),
    .size      (size_q),
    .in_bounds (nb_in),
    .adr       (nb_adr)
  );

  always_comb begin
    size_in = board_size;
    if (board_size == 5'd0)                size_in = 5'd1;
    else if (board_size > 5'(MAX_SIZE))    size_in = 5'(MAX_SIZE);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    self_d  = self_q;
    size_d  = size_q;
    wait_d  = wait_q;
    err_d   = err_q;
    stb     = 1'b0;
    we      = 1'b0;
    adr     = 8'h00;
    dat     = 8'h00;
    last    = size_q - 5'd1;
    wr_fld  = self_q;
    wr_fld.mine_ind = cnt_q;
    is_wt   = (state_q == S_SELF_WT) || (state_q == S_NB_WT) || (state_q == S_WR_WT);
    timeout = (wait_q == WAIT_W'(ACK_TIMEOUT - 1));

    unique case (state_q)
      S_IDLE: if (start) begin
        size_d  = size_in;
        row_d   = 4'd0;
        col_d   = 4'd0;
        err_d   = 1'b0;
        state_d = S_SELF_RD;
      end
      S_SELF_RD: begin
        stb     = 1'b1;
        adr     = make_adr(row_q, col_q);
        wait_d  = '0;
        state_d = S_SELF_WT;
      end
      S_SELF_WT: if (wb.ACK_I) begin
        self_d  = field_t'(wb.DAT_I);
        cnt_d   = 4'd0;
        k_d     = 3'd0;
        state_d = S_NB_EVAL;
      end
      S_NB_EVAL: begin
        if (nb_in) begin
          stb     = 1'b1;
          adr     = nb_adr;
          wait_d  = '0;
          state_d = S_NB_WT;
        end else begin
          // Out-of-bounds neighbour: one idle cycle, no bus access.
          k_d = k_q + 3'd1;
          if (k_q == 3'd7) state_d = S_WR;
        end
      end
      S_NB_WT: if (wb.ACK_I) begin
        cnt_d   = cnt_q + {3'b000, wb.DAT_I[7]};
        k_d     = k_q + 3'd1;
        state_d = (k_q == 3'd7) ? S_WR : S_NB_EVAL;
      end
      S_WR: begin
        stb     = 1'b1;
        we      = 1'b1;
        adr     = make_adr(row_q, col_q);
        dat     = wr_fld;
        wait_d  = '0;
        state_d = S_WR_WT;
      end
      S_WR_WT: if (wb.ACK_I) state_d = S_ADV;
      S_ADV: begin
        if ({1'b0, col_q} == last) begin
          col_d = 4'd0;
          if ({1'b0, row_q} == last) state_d = S_DONE;
          else begin
            row_d   = row_q + 4'd1;
            state_d = S_SELF_RD;
          end
        end else begin
          col_d   = col_q + 4'd1;
          state_d = S_SELF_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Shared ACK watchdog for every wait state; abort goes through DONE
    // so the done pulse and CYC drop happen the same way as a normal end.
    if (is_wt && !wb.ACK_I) begin
      if (timeout) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      self_q  <= '0;
      size_q  <= 5'd1;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      self_q  <= self_d;
      size_q  <= size_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign wb.CYC_O = (state_q != S_IDLE) && (state_q != S_DONE);
  assign wb.STB_O = stb;
  assign wb.WE_O  = we;
  assign wb.ADR_O = adr;
  assign wb.DAT_O = dat;

endmodule

// File: tb/tb_board_indicator_calc.sv
// Directed bench for board_indicator_calc with a 256-byte board memory model
// that ACKs one cycle after each strobe (optionally withholding one ACK).
module tb_board_indicator_calc;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] board_size;
  logic       busy, done, err;

  wishbone_if wb ();

  board_indicator_calc #(.MAX_SIZE(16), .ACK_TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .board_size (board_size),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .wb         (wb)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory model / slave
  logic [7:0] mem [256];
  logic       fill_req = 1'b0, poke_req = 1'b0;
  logic [7:0] fill_val = 8'h00, poke_val = 8'h00, poke_adr = 8'h00;
  int         withhold_n = 0;
  int         strobe_cnt = 0;
  int         wr_cnt = 0;

  always @(posedge clk) begin
    wb.ACK_I <= 1'b0;
    if (fill_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= fill_val;
      strobe_cnt <= 0;
      wr_cnt     <= 0;
    end else if (poke_req) begin
      mem[poke_adr] <= poke_val;
    end
    if (wb.CYC_O === 1'b1 && wb.STB_O === 1'b1) begin
      strobe_cnt <= strobe_cnt + 1;
      if (!(withhold_n != 0 && strobe_cnt + 1 == withhold_n)) begin
        wb.ACK_I <= 1'b1;
        wb.DAT_I <= mem[wb.ADR_O];
        if (wb.WE_O) begin
          mem[wb.ADR_O] <= wb.DAT_O;
          wr_cnt        <= wr_cnt + 1;
        end
      end
    end
  end

  // Cycle / pulse monitors
  int cyc_cnt = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (wb.CYC_O === 1'b1) cyc_cnt <= cyc_cnt + 1;
    if (done === 1'b1)     done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cell(input int r, input int c, input logic [7:0] exp);
    logic [7:0] v;
    v = mem[r * 16 + c];
    chk($sformatf("cell_%0d_%0d", r, c), {24'h0, v}, {24'h0, exp});
  endtask

  task automatic fill(input logic [7:0] v);
    @(negedge clk); fill_val = v; fill_req = 1'b1;
    @(negedge clk); fill_req = 1'b0;
  endtask

  task automatic poke(input int r, input int c, input logic [7:0] v);
    @(negedge clk); poke_adr = 8'(r * 16 + c); poke_val = v; poke_req = 1'b1;
    @(negedge clk); poke_req = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] s);
    @(negedge clk); start = 1'b1; board_size = s;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  int c0, d0, gaps;
  bit seen;
  logic [7:0] e;

  initial begin
    rst = 1'b1; start = 1'b0; board_size = 5'd0;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err",  err,  1'b0);
    chk("rst_cyc",  wb.CYC_O, 1'b0);
    chk("rst_stb",  wb.STB_O, 1'b0);
    chk("rst_we",   wb.WE_O,  1'b0);
    chk("rst_adr",  wb.ADR_O, 8'h00);
    chk("rst_dat",  wb.DAT_O, 8'h00);
    rst = 1'b0;

    // Size 4, one mine at (1,1); extra starts mid-sweep and in DONE cycle
    fill(8'h00);
    poke(1, 1, 8'h80);
    c0 = cyc_cnt; d0 = done_cnt;
    pulse_start(5'd4);
    chk("busy_after_start", busy, 1'b1);
    gaps = 0; seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = (i == 40);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) gaps++;
    end
    chk("s4_done_seen", seen, 1'b1);
    chk("s4_err", err, 1'b0);
    chk("s4_cycles", c1(c0), 292);
    chk("s4_busy_gaps", gaps, 0);
    start = 1'b1;                       // start during DONE cycle
    @(negedge clk); start = 1'b0;
    chk("s4_idle_cyc", wb.CYC_O, 1'b0);
    chk("s4_idle_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("s4_still_idle", busy, 1'b0);
    chk("s4_done_pulses", done_cnt - d0, 1);
    chk("s4_writes", wr_cnt, 16);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        e = (r == 1 && c == 1) ? 8'h80 : (r <= 2 && c <= 2) ? 8'h02 : 8'h00;
        chk_cell(r, c, e);
      end

    // Size 16, all mines
    fill(8'h80);
    c0 = cyc_cnt;
    pulse_start(5'd16);
    wait_done(6000, seen);
    chk("s16_done_seen", seen, 1'b1);
    chk("s16_err", err, 1'b0);
    chk("s16_cycles", c1(c0), 5188);
    chk_cell(0, 0, 8'h86);   chk_cell(0, 15, 8'h86);
    chk_cell(15, 0, 8'h86);  chk_cell(15, 15, 8'h86);
    chk_cell(0, 5, 8'h8A);   chk_cell(7, 0, 8'h8A);
    chk_cell(15, 9, 8'h8A);  chk_cell(3, 15, 8'h8A);
    chk_cell(1, 1, 8'h90);   chk_cell(8, 8, 8'h90);
    chk_cell(14, 14, 8'h90);

    // Size 3, flag/defused/rsvd bits preserved, no mines
    fill(8'h61);
    pulse_start(5'd3);
    wait_done(400, seen);
    chk("s3_done_seen", seen, 1'b1);
    repeat (2) @(negedge clk);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) chk_cell(r, c, 8'h61);
    chk("s3_writes", wr_cnt, 9);

    // ACK withheld on the 5th access (write of cell (0,0))
    withhold_n = 5;
    fill(8'h00);
    c0 = cyc_cnt;
    pulse_start(5'd4);
    wait_done(100, seen);
    chk("to_done_seen", seen, 1'b1);
    chk("to_err", err, 1'b1);
    chk("to_cyc", wb.CYC_O, 1'b0);
    chk("to_stb", wb.STB_O, 1'b0);
    chk("to_cycles", c1(c0), 29);
    withhold_n = 0;
    fill(8'h80);
    pulse_start(5'd2);
    chk("to_err_cleared", err, 1'b0);
    wait_done(200, seen);
    chk("s2_done_seen", seen, 1'b1);
    chk("s2_err", err, 1'b0);
    repeat (2) @(negedge clk);
    chk_cell(0, 0, 8'h86);
    chk_cell(1, 1, 8'h86);

    // Reset while waiting on a neighbour read
    fill(8'h00);
    pulse_start(5'd3);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (strobe_cnt == 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rs_reached_nbwt", seen, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rs_cyc", wb.CYC_O, 1'b0);
    chk("rs_stb", wb.STB_O, 1'b0);
    chk("rs_busy", busy, 1'b0);
    rst = 1'b0;
    fill(8'h00);
    poke(2, 2, 8'h80);
    pulse_start(5'd3);
    wait_done(400, seen);
    chk("rs_done_seen", seen, 1'b1);
    repeat (2) @(negedge clk);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        e = (r == 2 && c == 2) ? 8'h80 : (r >= 1 && c >= 1) ? 8'h02 : 8'h00;
        chk_cell(r, c, e);
      end

    // board_size = 0 -> 1x1 sweep
    fill(8'hFF);
    c0 = cyc_cnt;
    pulse_start(5'd0);
    wait_done(50, seen);
    chk("s1_done_seen", seen, 1'b1);
    chk("s1_cycles", c1(c0), 13);
    repeat (2) @(negedge clk);
    chk("s1_strobes", strobe_cnt, 2);
    chk("s1_writes", wr_cnt, 1);
    chk_cell(0, 0, 8'hE1);
    chk_cell(0, 1, 8'hFF);
    chk_cell(1, 0, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic int c1(input int base);
    return cyc_cnt - base;
  endfunction

endmodule
